// File: rtl/wb_pkg.sv
// Shared types for the queued Wishbone classic master.
//   wb_command_t : command code presented on cmd_in (NONE/LOAD/STORE)
//   wb_status_t  : completion status returned on rsp_status_out
package wb_pkg;

    typedef enum logic [1:0] {
        CMD_NONE  = 2'd0,
        CMD_LOAD  = 2'd1,
        CMD_STORE = 2'd2
    } wb_command_t;

    typedef enum logic [1:0] {
        ST_OK      = 2'd0,
        ST_ERR     = 2'd1,
        ST_TIMEOUT = 2'd2,
        ST_RETRY   = 2'd3
    } wb_status_t;

endpackage

// File: rtl/wb_cmd_fifo.sv
// Synchronous command FIFO for wb_master_q.
// Storage and pointers are registers; the head entry is read straight out of
// the storage array so a command pushed on one edge can be popped on the next.
// Ports:
//   clk_in, reset_in   clock, synchronous active-high reset (flushes pointers)
//   push_in, data_in   write request and entry; ignored while full
//   pop_in             read request; ignored while empty
//   data_out           head entry (valid while empty_out is low)
//   empty_out, full_out occupancy flags
module wb_cmd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk_in,
    input  logic             reset_in,
    input  logic             push_in,
    input  logic [WIDTH-1:0] data_in,
    input  logic             pop_in,
    output logic [WIDTH-1:0] data_out,
    output logic             empty_out,
    output logic             full_out
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push_ok;
    logic             pop_ok;

    assign empty_out = (wr_ptr_q == rd_ptr_q);
    assign full_out  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push_ok   = push_in && !full_out;
    assign pop_ok    = pop_in && !empty_out;
    assign data_out  = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= data_in;
        end
    end

endmodule

// File: rtl/wb_master_q.sv
// Wishbone classic master with a queued command port.
// Commands (LOAD/STORE with address, data, byte mask) are pushed into a small
// FIFO and executed one at a time on the bus; every command produces exactly
// one status-tagged response pulse. A watchdog aborts a transfer whose slave
// never terminates it.
// Optional feature macro: WB_MASTER_Q_RTY_EN
//   defined    : wb_rty causes a one-cycle BACKOFF and a reissue of the same
//                command, up to RETRY_MAX reissues, then status RETRY.
//   undefined  : wb_rty terminates the command exactly like wb_err.
// Ports:
//   clk_in, reset_in                 clock, synchronous active-high reset
//   cmd_in, addr_in, wdata_in, wmask_in, cmd_ready_out   command push side
//   rsp_valid_out, rsp_status_out, rdata_out             response side
//   busy_out                         queue non-empty or transfer in flight
//   wb_cyc, wb_stb, wb_we, wb_addr, wb_wdata, wb_sel     bus outputs
//   wb_ack, wb_err, wb_rty, wb_rdata                     bus inputs
module wb_master_q
    import wb_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int CMD_DEPTH      = 2,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int RETRY_MAX      = 3
) (
    input  logic                  clk_in,
    input  logic                  reset_in,
    input  wb_command_t           cmd_in,
    output logic                  cmd_ready_out,
    input  logic [ADDR_W-1:0]     addr_in,
    input  logic [DATA_W-1:0]     wdata_in,
    input  logic [DATA_W/8-1:0]   wmask_in,
    output logic                  rsp_valid_out,
    output wb_status_t            rsp_status_out,
    output logic [DATA_W-1:0]     rdata_out,
    output logic                  busy_out,
    output logic                  wb_cyc,
    output logic                  wb_stb,
    output logic                  wb_we,
    output logic [ADDR_W-1:0]     wb_addr,
    output logic [DATA_W-1:0]     wb_wdata,
    output logic [DATA_W/8-1:0]   wb_sel,
    input  logic                  wb_ack,
    input  logic                  wb_err,
    input  logic                  wb_rty,
    input  logic [DATA_W-1:0]     wb_rdata
);

    localparam int SEL_W  = DATA_W / 8;
    localparam int FIFO_W = 1 + ADDR_W + DATA_W + SEL_W;

    // A zero TIMEOUT_CYCLES disables the watchdog; keep a 1-bit counter then.
    localparam int              TO_W    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic            TO_EN   = (TIMEOUT_CYCLES > 0);
    localparam logic [TO_W-1:0] TO_LAST = (TIMEOUT_CYCLES > 0) ? TO_W'(TIMEOUT_CYCLES - 1) : '0;

`ifdef WB_MASTER_Q_RTY_EN
    localparam int              RT_W    = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;
    localparam logic [RT_W-1:0] RT_LAST = RT_W'(RETRY_MAX);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACTIVE  = 2'd1,
        S_BACKOFF = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1
    } state_t;

    // RETRY_MAX only has meaning when retries are built in.
    logic unused_retry_cfg;
    assign unused_retry_cfg = (RETRY_MAX != 0);
`endif

    // Saturating increment: the watchdog counter must never wrap to zero.
    function automatic logic [TO_W-1:0] sat_inc(input logic [TO_W-1:0] v);
        return (v == {TO_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    // ------------------------------------------------------------------
    // Command queue
    // ------------------------------------------------------------------
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_empty;
    logic              fifo_full;
    logic [FIFO_W-1:0] fifo_din;
    logic [FIFO_W-1:0] fifo_dout;
    logic              head_store;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_wdata;
    logic [SEL_W-1:0]  head_mask;

    assign fifo_push = (cmd_in != CMD_NONE) && !fifo_full;
    assign fifo_din  = {(cmd_in == CMD_STORE), addr_in, wdata_in, wmask_in};
    assign {head_store, head_addr, head_wdata, head_mask} = fifo_dout;

    wb_cmd_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (CMD_DEPTH)
    ) u_fifo (
        .clk_in    (clk_in),
        .reset_in  (reset_in),
        .push_in   (fifo_push),
        .data_in   (fifo_din),
        .pop_in    (fifo_pop),
        .data_out  (fifo_dout),
        .empty_out (fifo_empty),
        .full_out  (fifo_full)
    );

    // ------------------------------------------------------------------
    // Transfer FSM, watchdog, bus and response registers
    // ------------------------------------------------------------------
    state_t            state_q, state_d;
    logic              cyc_q, cyc_d;
    logic              stb_q, stb_d;
    logic              we_q, we_d;
    logic              store_q, store_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic              rsp_valid_q, rsp_valid_d;
    wb_status_t        rsp_status_q, rsp_status_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
`ifdef WB_MASTER_Q_RTY_EN
    logic [RT_W-1:0]   retry_cnt_q, retry_cnt_d;
`endif
    logic              term;
    wb_status_t        term_status;
    logic              to_hit;

    assign to_hit = TO_EN && (to_cnt_q == TO_LAST);

    always_comb begin
        state_d      = state_q;
        cyc_d        = cyc_q;
        stb_d        = stb_q;
        we_d         = we_q;
        store_d      = store_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        sel_d        = sel_q;
        rsp_valid_d  = 1'b0;
        rsp_status_d = rsp_status_q;
        rdata_d      = rdata_q;
        to_cnt_d     = to_cnt_q;
`ifdef WB_MASTER_Q_RTY_EN
        retry_cnt_d  = retry_cnt_q;
`endif
        fifo_pop     = 1'b0;
        term         = 1'b0;
        term_status  = ST_OK;

        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    store_d  = head_store;
                    addr_d   = head_addr;
                    wdata_d  = head_wdata;
                    // Loads always request every byte lane.
                    sel_d    = head_store ? head_mask : {SEL_W{1'b1}};
                    we_d     = head_store;
                    cyc_d    = 1'b1;
                    stb_d    = 1'b1;
                    to_cnt_d = '0;
`ifdef WB_MASTER_Q_RTY_EN
                    retry_cnt_d = '0;
`endif
                    state_d  = S_ACTIVE;
                end
            end

            S_ACTIVE: begin
                to_cnt_d = sat_inc(to_cnt_q);
                // Termination priority: err > ack > rty > watchdog.
                if (wb_err) begin
                    term        = 1'b1;
                    term_status = ST_ERR;
                end else if (wb_ack) begin
                    term        = 1'b1;
                    term_status = ST_OK;
                    if (!store_q) begin
                        rdata_d = wb_rdata;
                    end
                end else if (wb_rty) begin
`ifdef WB_MASTER_Q_RTY_EN
                    if (retry_cnt_q == RT_LAST) begin
                        term        = 1'b1;
                        term_status = ST_RETRY;
                    end else begin
                        retry_cnt_d = retry_cnt_q + 1'b1;
                        cyc_d       = 1'b0;
                        stb_d       = 1'b0;
                        we_d        = 1'b0;
                        state_d     = S_BACKOFF;
                    end
`else
                    term        = 1'b1;
                    term_status = ST_ERR;
`endif
                end else if (to_hit) begin
                    term        = 1'b1;
                    term_status = ST_TIMEOUT;
                end
            end

`ifdef WB_MASTER_Q_RTY_EN
            S_BACKOFF: begin
                // Reissue the latched command with a fresh watchdog window.
                cyc_d    = 1'b1;
                stb_d    = 1'b1;
                we_d     = store_q;
                to_cnt_d = '0;
                state_d  = S_ACTIVE;
            end
`endif

            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (term) begin
            cyc_d        = 1'b0;
            stb_d        = 1'b0;
            we_d         = 1'b0;
            rsp_valid_d  = 1'b1;
            rsp_status_d = term_status;
            state_d      = S_IDLE;
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_q      <= S_IDLE;
            cyc_q        <= 1'b0;
            stb_q        <= 1'b0;
            we_q         <= 1'b0;
            store_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            sel_q        <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_status_q <= ST_OK;
            rdata_q      <= '0;
            to_cnt_q     <= '0;
`ifdef WB_MASTER_Q_RTY_EN
            retry_cnt_q  <= '0;
`endif
        end else begin
            state_q      <= state_d;
            cyc_q        <= cyc_d;
            stb_q        <= stb_d;
            we_q         <= we_d;
            store_q      <= store_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            sel_q        <= sel_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_status_q <= rsp_status_d;
            rdata_q      <= rdata_d;
            to_cnt_q     <= to_cnt_d;
`ifdef WB_MASTER_Q_RTY_EN
            retry_cnt_q  <= retry_cnt_d;
`endif
        end
    end

    assign cmd_ready_out  = !fifo_full;
    assign busy_out       = !fifo_empty || (state_q != S_IDLE);
    assign rsp_valid_out  = rsp_valid_q;
    assign rsp_status_out = rsp_status_q;
    assign rdata_out      = rdata_q;
    assign wb_cyc         = cyc_q;
    assign wb_stb         = stb_q;
    assign wb_we          = we_q;
    assign wb_addr        = addr_q;
    assign wb_wdata       = wdata_q;
    assign wb_sel         = sel_q;

endmodule

// File: tb/tb_wb_master_q.sv
// Self-checking bench for wb_master_q: table of single-command vectors with
// hand-computed results, plus sequences for back-to-back issue, queue full
// and reset during an active transfer. A negedge slave model terminates
// transfers according to the current mode/delay.
module tb_wb_master_q;
    import wb_pkg::*;

    localparam int M_NONE   = 0;
    localparam int M_ACK    = 1;
    localparam int M_ERR    = 2;
    localparam int M_RTY    = 3;
    localparam int M_ACKERR = 4;

`ifdef WB_MASTER_Q_RTY_EN
    localparam wb_status_t RTY_ST       = ST_RETRY;
    localparam int         RTY_ATTEMPTS = 3;
`else
    localparam wb_status_t RTY_ST       = ST_ERR;
    localparam int         RTY_ATTEMPTS = 1;
`endif

    logic        clk = 1'b0;
    logic        reset_in = 1'b1;
    wb_command_t cmd_in = CMD_NONE;
    logic [31:0] addr_in = '0;
    logic [31:0] wdata_in = '0;
    logic [3:0]  wmask_in = '0;
    logic        cmd_ready_out;
    logic        rsp_valid_out;
    wb_status_t  rsp_status_out;
    logic [31:0] rdata_out;
    logic        busy_out;
    logic        wb_cyc, wb_stb, wb_we;
    logic [31:0] wb_addr, wb_wdata;
    logic [3:0]  wb_sel;
    logic        wb_ack = 1'b0;
    logic        wb_err = 1'b0;
    logic        wb_rty = 1'b0;
    logic [31:0] wb_rdata = '0;

    wb_master_q #(
        .ADDR_W         (32),
        .DATA_W         (32),
        .CMD_DEPTH      (2),
        .TIMEOUT_CYCLES (8),
        .RETRY_MAX      (2)
    ) dut (
        .clk_in         (clk),
        .reset_in       (reset_in),
        .cmd_in         (cmd_in),
        .cmd_ready_out  (cmd_ready_out),
        .addr_in        (addr_in),
        .wdata_in       (wdata_in),
        .wmask_in       (wmask_in),
        .rsp_valid_out  (rsp_valid_out),
        .rsp_status_out (rsp_status_out),
        .rdata_out      (rdata_out),
        .busy_out       (busy_out),
        .wb_cyc         (wb_cyc),
        .wb_stb         (wb_stb),
        .wb_we          (wb_we),
        .wb_addr        (wb_addr),
        .wb_wdata       (wb_wdata),
        .wb_sel         (wb_sel),
        .wb_ack         (wb_ack),
        .wb_err         (wb_err),
        .wb_rty         (wb_rty),
        .wb_rdata       (wb_rdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Slave model / monitor state
    int          slv_mode = M_NONE;
    int          slv_delay = 0;
    int          slv_cnt = 0;
    int          stb_cnt = 0;
    int          attempt_cnt = 0;
    int          rsp_cnt = 0;
    int          cyc_low_run = 0;
    int          last_gap = 0;
    wb_status_t  last_status = ST_OK;
    logic [31:0] seen_addr = '0;
    logic [31:0] seen_wdata = '0;
    logic [3:0]  seen_sel = '0;
    logic        seen_we = 1'b0;

    always @(negedge clk) begin
        if (rsp_valid_out) begin
            rsp_cnt     = rsp_cnt + 1;
            last_status = rsp_status_out;
        end
        if (wb_cyc && wb_stb) begin
            if (cyc_low_run > 0) last_gap = cyc_low_run;
            cyc_low_run = 0;
            slv_cnt = slv_cnt + 1;
            stb_cnt = stb_cnt + 1;
            if (slv_cnt == 1) begin
                attempt_cnt = attempt_cnt + 1;
                seen_addr   = wb_addr;
                seen_wdata  = wb_wdata;
                seen_sel    = wb_sel;
                seen_we     = wb_we;
            end
            if (slv_mode != M_NONE && slv_cnt > slv_delay) begin
                wb_ack = (slv_mode == M_ACK) || (slv_mode == M_ACKERR);
                wb_err = (slv_mode == M_ERR) || (slv_mode == M_ACKERR);
                wb_rty = (slv_mode == M_RTY);
            end
        end else begin
            slv_cnt = 0;
            wb_ack  = 1'b0;
            wb_err  = 1'b0;
            wb_rty  = 1'b0;
            if (!wb_cyc) cyc_low_run = cyc_low_run + 1;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at posedge+1; inputs are sampled at the next posedge.
    task automatic push(input wb_command_t c, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] m);
        cmd_in   = c;
        addr_in  = a;
        wdata_in = d;
        wmask_in = m;
        @(posedge clk);
        #1;
        cmd_in = CMD_NONE;
    endtask

    task automatic wait_rsp(input int target, input string name);
        for (int k = 0; k < 80 && rsp_cnt < target; k++) begin
            @(posedge clk);
            #1;
        end
        check(name, 64'(rsp_cnt), 64'(target));
    endtask

    typedef struct {
        wb_command_t cmd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
        int          mode;
        int          delay;
        logic [31:0] srdata;
        wb_status_t  st;
        logic [3:0]  sel;
        logic        we;
        logic [31:0] rdata;
        int          stbs;
        int          attempts;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int prev;

        //          cmd        addr        wdata         mask     mode      dly srdata        status      sel      we    rdata_out     stbs attempts
        vecs[0] = '{CMD_STORE, 32'h100, 32'hDEADBEEF, 4'b0011, M_ACK,    2, 32'h0,        ST_OK,      4'b0011, 1'b1, 32'h0,        3, 1};
        vecs[1] = '{CMD_LOAD,  32'h200, 32'h0,        4'b0000, M_ACK,    1, 32'hCAFEF00D, ST_OK,      4'b1111, 1'b0, 32'hCAFEF00D, 2, 1};
        vecs[2] = '{CMD_LOAD,  32'h300, 32'h0,        4'b0000, M_NONE,   0, 32'h55555555, ST_TIMEOUT, 4'b1111, 1'b0, 32'hCAFEF00D, 8, 1};
        vecs[3] = '{CMD_LOAD,  32'h400, 32'h0,        4'b0000, M_ACKERR, 0, 32'h11111111, ST_ERR,     4'b1111, 1'b0, 32'hCAFEF00D, 1, 1};
        vecs[4] = '{CMD_LOAD,  32'h500, 32'h0,        4'b0000, M_ACK,    0, 32'h12345678, ST_OK,      4'b1111, 1'b0, 32'h12345678, 1, 1};
        vecs[5] = '{CMD_LOAD,  32'h600, 32'h0,        4'b0000, M_ERR,    0, 32'h9ABCDEF0, ST_ERR,     4'b1111, 1'b0, 32'h12345678, 1, 1};
        vecs[6] = '{CMD_LOAD,  32'h700, 32'h0,        4'b0000, M_RTY,    0, 32'hA5A5A5A5, RTY_ST,     4'b1111, 1'b0, 32'h12345678, RTY_ATTEMPTS, RTY_ATTEMPTS};
        vecs[7] = '{CMD_STORE, 32'h800, 32'h0BADF00D, 4'b1100, M_ACK,    0, 32'hFFFFFFFF, ST_OK,      4'b1100, 1'b1, 32'h12345678, 1, 1};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_cyc",   64'(wb_cyc), 64'(0));
        check("reset_stb",   64'(wb_stb), 64'(0));
        check("reset_rsp",   64'(rsp_valid_out), 64'(0));
        check("reset_ready", 64'(cmd_ready_out), 64'(1));
        check("reset_busy",  64'(busy_out), 64'(0));
        check("reset_rdata", 64'(rdata_out), 64'(0));
        check("reset_addr",  64'(wb_addr), 64'(0));
        reset_in = 1'b0;
        @(posedge clk);
        #1;

        // Single-command vectors
        for (int i = 0; i < 8; i++) begin
            slv_mode    = vecs[i].mode;
            slv_delay   = vecs[i].delay;
            wb_rdata    = vecs[i].srdata;
            stb_cnt     = 0;
            attempt_cnt = 0;
            prev        = rsp_cnt;
            push(vecs[i].cmd, vecs[i].addr, vecs[i].wdata, vecs[i].mask);
            wait_rsp(prev + 1, $sformatf("v%0d_rsp_seen", i));
            check($sformatf("v%0d_status", i),   64'(last_status), 64'(vecs[i].st));
            check($sformatf("v%0d_addr", i),     64'(seen_addr), 64'(vecs[i].addr));
            check($sformatf("v%0d_sel", i),      64'(seen_sel), 64'(vecs[i].sel));
            check($sformatf("v%0d_we", i),       64'(seen_we), 64'(vecs[i].we));
            if (vecs[i].cmd == CMD_STORE)
                check($sformatf("v%0d_wdata", i), 64'(seen_wdata), 64'(vecs[i].wdata));
            check($sformatf("v%0d_rdata_out", i), 64'(rdata_out), 64'(vecs[i].rdata));
            check($sformatf("v%0d_stb_cycles", i), 64'(stb_cnt), 64'(vecs[i].stbs));
            check($sformatf("v%0d_attempts", i), 64'(attempt_cnt), 64'(vecs[i].attempts));
            repeat (2) @(posedge clk);
            #1;
            check($sformatf("v%0d_one_rsp", i), 64'(rsp_cnt), 64'(prev + 1));
            check($sformatf("v%0d_busy", i),    64'(busy_out), 64'(0));
        end

        // Back-to-back commands with immediate acks: one idle cycle between
        slv_mode  = M_ACK;
        slv_delay = 0;
        wb_rdata  = 32'h0F0F0F0F;
        prev      = rsp_cnt;
        last_gap  = 0;
        push(CMD_STORE, 32'hA00, 32'h01020304, 4'b1111);
        push(CMD_LOAD,  32'hB00, 32'h0, 4'b0000);
        wait_rsp(prev + 2, "b2b_rsp_seen");
        check("b2b_status",    64'(last_status), 64'(ST_OK));
        check("b2b_cyc_gap",   64'(last_gap), 64'(1));
        check("b2b_last_addr", 64'(seen_addr), 64'(32'hB00));
        check("b2b_rdata",     64'(rdata_out), 64'(32'h0F0F0F0F));
        repeat (2) @(posedge clk);
        #1;

        // Queue fills while the first command is stalled on the bus
        slv_mode  = M_ACK;
        slv_delay = 3;
        prev      = rsp_cnt;
        push(CMD_LOAD, 32'hC00, 32'h0, 4'b0000);
        push(CMD_LOAD, 32'hC04, 32'h0, 4'b0000);
        push(CMD_LOAD, 32'hC08, 32'h0, 4'b0000);
        check("full_ready", 64'(cmd_ready_out), 64'(0));
        check("full_busy",  64'(busy_out), 64'(1));
        wait_rsp(prev + 3, "full_rsp_seen");
        check("full_last_addr", 64'(seen_addr), 64'(32'hC08));
        check("full_ready_after", 64'(cmd_ready_out), 64'(1));
        repeat (2) @(posedge clk);
        #1;

        // Reset during an active transfer: abort without a response
        slv_mode = M_NONE;
        prev     = rsp_cnt;
        push(CMD_LOAD, 32'hD00, 32'h0, 4'b0000);
        for (int k = 0; k < 10 && !wb_stb; k++) begin
            @(posedge clk);
            #1;
        end
        check("rst_mid_started", 64'(wb_stb), 64'(1));
        repeat (2) @(posedge clk);
        #1;
        reset_in = 1'b1;
        @(posedge clk);
        #1;
        reset_in = 1'b0;
        check("rst_mid_cyc",   64'(wb_cyc), 64'(0));
        check("rst_mid_stb",   64'(wb_stb), 64'(0));
        check("rst_mid_ready", 64'(cmd_ready_out), 64'(1));
        check("rst_mid_busy",  64'(busy_out), 64'(0));
        check("rst_mid_rdata", 64'(rdata_out), 64'(0));
        repeat (12) @(posedge clk);
        #1;
        check("rst_mid_no_rsp", 64'(rsp_cnt), 64'(prev));
        check("rst_mid_idle",   64'(wb_cyc), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
